// File: rtl/arb_rr_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   state_e : arbiter FSM encoding (ST_IDLE = no owner, ST_GRANT = owner latched in gnt)
//   NREQ    : number of requesters
//   HOLD_W  : width of the hold-time counter
package arb_rr_4_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/arb_rr_4_if.sv
// Request/grant bundle between the requesting units and the arbiter.
//   req       : request vector, one bit per requester
//   gnt       : one-hot grant (all-zero when nothing is granted)
//   gnt_idx   : binary index of the granted requester, 0 when none
//   gnt_valid : high whenever gnt is non-zero
// Modports: master = requester side, slave = arbiter side.
interface arb_rr_4_if;
  import arb_rr_4_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_idx;
  logic            gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/onehot_enc_4x2.sv
// Combinational one-hot to binary encoder.
//   onehot : 4-bit one-hot input (bit i set -> i); all-zero input encodes to 0
//   idx    : 2-bit binary index
module onehot_enc_4x2
  import arb_rr_4_pkg::*;
(
  input  logic [NREQ-1:0] onehot,
  output logic [1:0]      idx
);

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (onehot[i]) idx = 2'(i);
    end
  end

endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with bounded hold time.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/grant bundle (slave side); all outputs are registered
// Parameter MAX_HOLD (1..255): longest run of consecutive cycles one owner may keep the
// grant while another requester is waiting.
module arb_rr_4
  import arb_rr_4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  arb_rr_4_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q;
  logic [1:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [NREQ-1:0]   req_other;
  logic              rel;
  logic [2:0]        pick_req, pick_other;

  // Returns {found, index} of the first set bit scanning start, start+1, ... (mod 4).
  // Scanning backwards lets the earliest position in search order overwrite later ones.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    req_other  = bus.req & ~gnt_q;
    // Drop takes precedence over timeout; both simply mean "release" here.
    rel        = ~bus.req[gnt_idx_q] | (hold_q == HoldMax);
    // In ST_GRANT ptr_q already holds owner+1, so both searches start after the owner.
    pick_req   = rr_pick(bus.req, ptr_q);
    pick_other = rr_pick(req_other, ptr_q);

    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_req[2]) begin
          state_d = ST_GRANT;
          gnt_d   = NREQ'(1) << pick_req[1:0];
          ptr_d   = pick_req[1:0] + 2'd1;
          hold_d  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (!rel) begin
          if (hold_q != HoldMax) hold_d = hold_q + HOLD_W'(1);
        end else if (pick_other[2]) begin
          // Direct handover, no idle cycle in between.
          gnt_d  = NREQ'(1) << pick_other[1:0];
          ptr_d  = pick_other[1:0] + 2'd1;
          hold_d = HOLD_W'(1);
        end else if (bus.req[gnt_idx_q]) begin
          // Timed out with nobody else waiting: re-grant the same owner.
          ptr_d  = gnt_idx_q + 2'd1;
          hold_d = HOLD_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  onehot_enc_4x2 u_enc (
    .onehot (gnt_d),
    .idx    (gnt_idx_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= 2'd0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= |gnt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Bench for arb_rr_4: three instances (MAX_HOLD = 8, 2, 1) share clock, reset and req.
// A behavioural model per instance (owner / pointer / cycles-held as integers) is compared
// against every instance on each falling edge; directed phases add literal expectations.
module tb_arb_rr_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  int tests = 0;
  int fails = 0;

  arb_rr_4_if if8 ();
  arb_rr_4_if if2 ();
  arb_rr_4_if if1 ();

  assign if8.req = req;
  assign if2.req = req;
  assign if1.req = req;

  arb_rr_4 #(.MAX_HOLD(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  arb_rr_4 #(.MAX_HOLD(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  arb_rr_4 #(.MAX_HOLD(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [3:0] g   [3];
  logic [1:0] gi  [3];
  logic       gv  [3];
  assign g[0] = if8.gnt;  assign gi[0] = if8.gnt_idx;  assign gv[0] = if8.gnt_valid;
  assign g[1] = if2.gnt;  assign gi[1] = if2.gnt_idx;  assign gv[1] = if2.gnt_valid;
  assign g[2] = if1.gnt;  assign gi[2] = if1.gnt_idx;  assign gv[2] = if1.gnt_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int maxh    [3] = '{8, 2, 1};
  int m_owner [3];   // -1 = nobody granted
  int m_ptr   [3];
  int m_held  [3];   // consecutive cycles the current owner has held the grant

  function automatic int first_in_order(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int mh, input logic [3:0] r,
                            input int owner, input int ptr, input int held,
                            output int n_owner, output int n_ptr, output int n_held);
    logic [3:0] others;
    int w;
    n_owner = owner; n_ptr = ptr; n_held = held;
    if (owner < 0) begin
      w = first_in_order(r, ptr);
      if (w >= 0) begin
        n_owner = w; n_held = 1; n_ptr = (w + 1) % 4;
      end
    end else begin
      others = r & ~(4'b0001 << owner);
      if (r[owner] && held < mh) begin
        n_held = held + 1;
      end else if (others != 4'b0000) begin
        w = first_in_order(others, (owner + 1) % 4);
        n_owner = w; n_held = 1; n_ptr = (w + 1) % 4;
      end else if (r[owner]) begin
        n_held = 1; n_ptr = (owner + 1) % 4;
      end else begin
        n_owner = -1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_owner[k] <= -1; m_ptr[k] <= 0; m_held[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int no, np, nh;
        model_step(maxh[k], req, m_owner[k], m_ptr[k], m_held[k], no, np, nh);
        m_owner[k] <= no; m_ptr[k] <= np; m_held[k] <= nh;
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      logic [1:0] ei;
      eg = (m_owner[k] < 0) ? 4'b0000 : 4'(4'b0001 << m_owner[k]);
      ei = (m_owner[k] < 0) ? 2'd0 : 2'(m_owner[k]);
      check($sformatf("model gnt mh=%0d", maxh[k]), 32'(g[k]), 32'(eg));
      check($sformatf("model gnt_idx mh=%0d", maxh[k]), 32'(gi[k]), 32'(ei));
      check($sformatf("model gnt_valid mh=%0d", maxh[k]), 32'(gv[k]), 32'(m_owner[k] >= 0));
      check($sformatf("onehot mh=%0d", maxh[k]), 32'($countones(g[k]) <= 1), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int rot2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int rot1 [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, single request, then asynchronous reset mid-grant.
    @(negedge clk);
    check("reset gnt", 32'(g[0]), 32'h0);
    check("reset gnt_valid", 32'(gv[0]), 32'h0);
    req = 4'b0100;
    @(negedge clk);
    check("single gnt", 32'(g[0]), 32'h4);
    check("single gnt_idx", 32'(gi[0]), 32'd2);
    check("single gnt_valid", 32'(gv[0]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("async rst gnt", 32'(g[k]), 32'h0);
      check("async rst gnt_idx", 32'(gi[k]), 32'h0);
      check("async rst gnt_valid", 32'(gv[k]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Full-load rotation.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("rot mh=2 step %0d", i), 32'(g[1]), 32'(4'b0001 << rot2[i]));
      if (i < 6) check($sformatf("rot mh=1 step %0d", i), 32'(g[2]), 32'(4'b0001 << rot1[i]));
    end

    // Drop handover: owner 1 drops while 3 waits.
    do_reset();
    req = 4'b1010;
    repeat (3) @(negedge clk);
    check("handover pre gnt", 32'(g[0]), 32'h2);
    req = 4'b1000;
    @(negedge clk);
    check("handover gnt", 32'(g[0]), 32'h8);
    check("handover gnt_idx", 32'(gi[0]), 32'd3);
    check("handover gnt_valid", 32'(gv[0]), 32'd1);

    // Sole owner past the hold limit keeps the grant continuously.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("sole owner cycle %0d", i), 32'(g[0]), 32'h1);
    end

    // Drop to idle, then pointer wrap from 3 to 0.
    do_reset();
    req = 4'b0100;
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("idle gnt", 32'(g[0]), 32'h0);
    check("idle gnt_valid", 32'(gv[0]), 32'h0);
    check("idle gnt_idx", 32'(gi[0]), 32'h0);
    req = 4'b0011;
    @(negedge clk);
    check("wrap gnt", 32'(g[0]), 32'h1);
    check("wrap gnt_idx", 32'(gi[0]), 32'd0);

    // Drop on the same cycle the hold limit is reached.
    do_reset();
    req = 4'b0110;
    repeat (8) @(negedge clk);
    check("no preempt before limit", 32'(g[0]), 32'h2);
    req = 4'b0100;
    @(negedge clk);
    check("drop+timeout gnt", 32'(g[0]), 32'h4);
    check("drop+timeout gnt_idx", 32'(gi[0]), 32'd2);

    // Randomized traffic with sticky requests and occasional resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_rr_4.md
# arb_rr_4

Four-requester round-robin arbiter with bounded hold time. It grants one of four requesters ownership of a shared resource, such as a shared output port or bus driven by the 4→2 encoder path. Grants are one-hot and also presented as a 2-bit binary index. All outputs are registered. The block sits between the requesting units and the shared resource's select logic.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant while others wait; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  request vector; req[i]=1 means requester i wants or keeps ownership.
- gnt  out  4  registered one-hot grant, or all-zero when nothing is granted.
- gnt_idx  out  2  binary index of the granted requester (gnt[i] → i); 0 when gnt_valid=0.
- gnt_valid  out  1  registered; equals |gnt.

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: owner registered in gnt.
- Priority pointer ptr (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - On every new grant to requester w, ptr ← w+1 mod 4.
- IDLE:
  - If req≠0: winner = first set bit in search order → GRANT, gnt ← onehot(w), hold_cnt ← 1.
  - If req=0: stay in IDLE.
- GRANT, with owner o. Release condition: req[o]=0 OR hold_cnt=MAX_HOLD.
  - No release: keep gnt; hold_cnt increments, saturating at MAX_HOLD.
  - Release, other requests pending (req & ~onehot(o) ≠ 0): switch directly to the winner among those requests (search from ptr = o+1), with no idle cycle; hold_cnt ← 1.
  - Release by timeout (req[o]=1) with no other request: o is re-granted; hold_cnt ← 1; ptr ← o+1.
  - Release by drop (req[o]=0) with no other request: gnt ← 0, → IDLE.
- Requests from non-owners never preempt before MAX_HOLD.
- gnt never has more than one bit set.
- gnt_idx is driven from the same register update as gnt.
- hold_cnt width is 8 bits.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0, state=IDLE.
  - After reset release, requester 0 has highest priority.
- Latency: req sampled at rising edge k; gnt, gnt_idx and gnt_valid change right after edge k, so they are visible during cycle k+1. There is no combinational path from req to any output.
- Owner drop: the owner deasserts req[o] before edge k. At edge k, gnt[o] falls and the next owner, if any, rises on the same edge.
- Timeout: the owner's grant lasts exactly MAX_HOLD cycles when others are waiting. A switch happens at the edge where hold_cnt=MAX_HOLD.
- MAX_HOLD=1: any waiting requester takes over after one cycle, giving strict rotation under full load.
- Simultaneous events:
  - Owner drop and timeout in the same cycle are treated as a drop.
  - New requests arriving on the release edge are eligible.

## Structure
- Shared package or header: state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1; the constant NREQ=4.
- Sub-module onehot_enc_4x2: combinational one-hot → binary encoder (bit i → i, zero input → 0). It produces the gnt_idx next value from the gnt next value.
- The round-robin search is a small function or block inside arb_rr_4. Target RTL size is about 150–250 lines.

## Test plan
- Reset and single request: assert rst_n=0 mid-grant → all outputs 0 immediately. Release reset, drive req=4'b0100 → gnt=4'b0100, gnt_idx=2, gnt_valid=1 one cycle later.
- Rotation under full load with MAX_HOLD=2 and req=4'b1111 held:
  - Grant sequence 0,0,1,1,2,2,3,3,0,…; each owner holds exactly 2 cycles.
  - gnt is always one-hot.
- Drop handover: owner 1 holds with req=4'b1010. Drop req[1] → at the next edge gnt=4'b1000, gnt_idx=3, with no zero cycle.
- Sole owner timeout: req=4'b0001 for 20 cycles with MAX_HOLD=8 → gnt stays at 4'b0001 continuously. hold_cnt wraps back to 1 every 8 cycles.
- Drop to idle: owner 2 drops with req=0 → gnt=0, gnt_valid=0, gnt_idx=0. Then assert req=4'b0011 → requester 3 is searched first but is not requesting, so requester 0 wins (ptr=3 wraps to 0).
- Simultaneous drop and timeout: the owner drops req on the cycle hold_cnt=MAX_HOLD while req=4'b0110 → handled as a drop; the next requester after the owner in search order is granted.
